// File: rtl/router_pkt_register.sv
// router_pkt_register: 1x3 router datapath stage that registers bytes to the FIFOs, latches the header, holds one byte across FIFO full, and checks packet parity
// Ports:
//   clk, reset (sync, active-low)
//   pkt_valid, data_in   source byte stream (pkt_valid low on the parity byte)
//   fifo_full            full flag of the addressed FIFO
//   detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  FSM strobes (one-hot or idle)
//   dout                 byte to FIFO write port
//   parity_done          parity byte has been taken
//   low_pkt_valid        pkt_valid fell during load
//   err                  parity mismatch for the current packet
module router_pkt_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pkt_valid,
  input  logic [WIDTH-1:0] data_in,
  input  logic             fifo_full,
  input  logic             detect_add,
  input  logic             lfd_state,
  input  logic             ld_state,
  input  logic             laf_state,
  input  logic             full_state,
  input  logic             rst_int_reg,
  output logic [WIDTH-1:0] dout,
  output logic             parity_done,
  output logic             low_pkt_valid,
  output logic             err
);
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] header_byte_q, header_byte_d;
  logic [WIDTH-1:0] full_byte_q, full_byte_d;
  logic [WIDTH-1:0] int_parity_q, int_parity_d;
  logic [WIDTH-1:0] pkt_parity_q, pkt_parity_d;
  logic             parity_done_q, parity_done_d;
  logic             low_pkt_valid_q, low_pkt_valid_d;
  logic             err_q, err_d;
  logic             take_ld, take_laf;
  always_comb begin
    // parity byte accepted directly, or replayed from full_byte after a full stall
    take_ld         = ld_state & ~fifo_full & ~pkt_valid;
    take_laf        = laf_state & low_pkt_valid_q & ~parity_done_q;
    header_byte_d   = (detect_add & pkt_valid & (data_in[1:0] != 2'b11)) ? data_in : header_byte_q;
    dout_d          = lfd_state ? header_byte_q :
                      ld_state  ? (fifo_full ? dout_q : data_in) :
                      laf_state ? full_byte_q : dout_q;
    full_byte_d     = (~lfd_state & ld_state & fifo_full) ? data_in : full_byte_q;
    low_pkt_valid_d = rst_int_reg ? 1'b0 : (ld_state & ~pkt_valid) ? 1'b1 : low_pkt_valid_q;
    parity_done_d   = detect_add ? 1'b0 : (take_ld | take_laf) ? 1'b1 : parity_done_q;
    pkt_parity_d    = detect_add ? '0 : take_ld ? data_in : take_laf ? full_byte_q : pkt_parity_q;
    // a byte stalled by full is folded once on its ld cycle, never again on replay
    int_parity_d    = detect_add ? '0 :
                      lfd_state ? (int_parity_q ^ header_byte_q) :
                      (ld_state & pkt_valid & ~full_state) ? (int_parity_q ^ data_in) : int_parity_q;
    err_d           = detect_add ? 1'b0 : parity_done_q ? (int_parity_q != pkt_parity_q) : err_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      dout_q          <= '0;
      header_byte_q   <= '0;
      full_byte_q     <= '0;
      int_parity_q    <= '0;
      pkt_parity_q    <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      dout_q          <= dout_d;
      header_byte_q   <= header_byte_d;
      full_byte_q     <= full_byte_d;
      int_parity_q    <= int_parity_d;
      pkt_parity_q    <= pkt_parity_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      err_q           <= err_d;
    end
  end
  assign dout          = dout_q;
  assign parity_done   = parity_done_q;
  assign low_pkt_valid = low_pkt_valid_q;
  assign err           = err_q;
endmodule

// File: tb/tb_router_pkt_register.sv
// tb_router_pkt_register: directed checks of the router packet register stage
`timescale 1ns/1ps
module tb_router_pkt_register;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pkt_valid = 1'b0;
  logic [7:0] data_in = '0;
  logic       fifo_full = 1'b0;
  logic       detect_add = 1'b0, lfd_state = 1'b0, ld_state = 1'b0;
  logic       laf_state = 1'b0, full_state = 1'b0, rst_int_reg = 1'b0;
  logic [7:0] dout;
  logic       parity_done, low_pkt_valid, err;
  int         vectors = 0;
  int         miscompares = 0;
  localparam logic [5:0] IDLE = 6'b000000, DA = 6'b100000, LFD = 6'b010000, LD = 6'b001000;
  localparam logic [5:0] LAF = 6'b000100, FULL = 6'b000010, RST = 6'b000001;
  always #5 clk = ~clk;
  router_pkt_register #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg),
    .dout(dout), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid), .err(err)
  );
  task automatic cyc(input logic [5:0] st, input logic pv, input logic [7:0] d, input logic ff);
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
    pkt_valid = pv;
    data_in = d;
    fifo_full = ff;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    cyc(IDLE, 0, 8'h00, 0);
    cyc(IDLE, 0, 8'h00, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_err", {7'b0, err}, 8'h00);
    chk("rst_parity_done", {7'b0, parity_done}, 8'h00);
    chk("rst_low_pkt_valid", {7'b0, low_pkt_valid}, 8'h00);
    reset = 1'b1;
    cyc(DA, 1, 8'h0D, 0);
    cyc(LFD, 1, 8'h0D, 0);
    chk("good_hdr", dout, 8'h0D);
    cyc(LD, 1, 8'h11, 0);
    chk("good_b1", dout, 8'h11);
    cyc(LD, 1, 8'h22, 0);
    chk("good_b2", dout, 8'h22);
    cyc(LD, 1, 8'h33, 0);
    chk("good_b3", dout, 8'h33);
    cyc(LD, 0, 8'h0D, 0);
    chk("good_par_dout", dout, 8'h0D);
    chk("good_parity_done", {7'b0, parity_done}, 8'h01);
    chk("good_low_pkt_valid", {7'b0, low_pkt_valid}, 8'h01);
    chk("good_err_early", {7'b0, err}, 8'h00);
    cyc(IDLE, 0, 8'h0D, 0);
    chk("good_err", {7'b0, err}, 8'h00);
    cyc(RST, 0, 8'h00, 0);
    chk("rst_int_clears_low", {7'b0, low_pkt_valid}, 8'h00);
    cyc(DA, 1, 8'h0D, 0);
    chk("da_clears_parity_done", {7'b0, parity_done}, 8'h00);
    cyc(LFD, 1, 8'h0D, 0);
    cyc(LD, 1, 8'h11, 0);
    cyc(LD, 1, 8'h22, 0);
    cyc(LD, 1, 8'h33, 0);
    cyc(LD, 0, 8'h0C, 0);
    chk("bad_parity_done", {7'b0, parity_done}, 8'h01);
    chk("bad_err_not_yet", {7'b0, err}, 8'h00);
    cyc(IDLE, 0, 8'h0C, 0);
    chk("bad_err", {7'b0, err}, 8'h01);
    cyc(RST, 0, 8'h00, 0);
    chk("bad_err_holds", {7'b0, err}, 8'h01);
    cyc(DA, 1, 8'h0F, 0);
    chk("da_clears_err", {7'b0, err}, 8'h00);
    cyc(LFD, 1, 8'h0F, 0);
    chk("invalid_addr_keeps_hdr", dout, 8'h0D);
    cyc(RST, 0, 8'h00, 0);
    cyc(DA, 1, 8'h0D, 0);
    cyc(LFD, 1, 8'h0D, 0);
    cyc(LD, 1, 8'h11, 0);
    chk("fm_b1", dout, 8'h11);
    cyc(LD, 1, 8'h22, 1);
    chk("fm_hold_ld", dout, 8'h11);
    cyc(FULL, 1, 8'h22, 1);
    chk("fm_hold_full", dout, 8'h11);
    cyc(LAF, 1, 8'h22, 0);
    chk("fm_laf_dout", dout, 8'h22);
    chk("fm_laf_no_parity_done", {7'b0, parity_done}, 8'h00);
    cyc(LD, 1, 8'h33, 0);
    chk("fm_b3", dout, 8'h33);
    cyc(LD, 0, 8'h0D, 0);
    chk("fm_parity_done", {7'b0, parity_done}, 8'h01);
    cyc(IDLE, 0, 8'h0D, 0);
    chk("fm_err", {7'b0, err}, 8'h00);
    cyc(RST, 0, 8'h00, 0);
    cyc(DA, 1, 8'h0D, 0);
    cyc(LFD, 1, 8'h0D, 0);
    cyc(LD, 1, 8'h11, 0);
    cyc(LD, 1, 8'h22, 0);
    cyc(LD, 1, 8'h33, 0);
    cyc(LD, 0, 8'h0D, 1);
    chk("fp_hold_dout", dout, 8'h33);
    chk("fp_no_parity_done", {7'b0, parity_done}, 8'h00);
    chk("fp_low_pkt_valid", {7'b0, low_pkt_valid}, 8'h01);
    cyc(FULL, 0, 8'h0D, 1);
    cyc(LAF, 0, 8'h0D, 0);
    chk("fp_laf_dout", dout, 8'h0D);
    chk("fp_laf_parity_done", {7'b0, parity_done}, 8'h01);
    cyc(IDLE, 0, 8'h0D, 0);
    chk("fp_err", {7'b0, err}, 8'h00);
    cyc(RST, 0, 8'h00, 0);
    cyc(DA, 1, 8'h0D, 0);
    cyc(LFD, 1, 8'h0D, 0);
    cyc(LD, 1, 8'h11, 0);
    chk("rm_b1", dout, 8'h11);
    reset = 1'b0;
    cyc(LD, 1, 8'h22, 0);
    chk("rm_dout", dout, 8'h00);
    chk("rm_err", {7'b0, err}, 8'h00);
    chk("rm_parity_done", {7'b0, parity_done}, 8'h00);
    chk("rm_low_pkt_valid", {7'b0, low_pkt_valid}, 8'h00);
    reset = 1'b1;
    cyc(DA, 1, 8'h0D, 0);
    cyc(LFD, 1, 8'h0D, 0);
    chk("ra_hdr", dout, 8'h0D);
    cyc(LD, 1, 8'h11, 0);
    cyc(LD, 1, 8'h22, 0);
    cyc(LD, 1, 8'h33, 0);
    cyc(LD, 0, 8'h0D, 0);
    chk("ra_parity_done", {7'b0, parity_done}, 8'h01);
    cyc(IDLE, 0, 8'h0D, 0);
    chk("ra_err", {7'b0, err}, 8'h00);
    cyc(LD | RST, 0, 8'h0D, 0);
    chk("clear_wins_low", {7'b0, low_pkt_valid}, 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
